// File: rtl/tcp_packet_rx_pkg.sv
// tcp_packet_rx_pkg: link constants, flag bit indices and receiver state encoding
package tcp_packet_rx_pkg;
    localparam logic [7:0] SOF = 8'hA5;
    localparam logic [7:0] MAXLEN = 8'd16;
    localparam int NSLOTS = 5;
    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [127:0] SPACES = {16{SPACE}};
    typedef enum logic [2:0] {S_IDLE, S_SEQ, S_ACK, S_FLAGS, S_LEN, S_PAY, S_CSUM} state_t;
endpackage

// File: rtl/tcp_packet_rx_history_shift.sv
// rx_history_shift: NSLOTS x 128-bit payload history, newest in the low slot
module rx_history_shift
    import tcp_packet_rx_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [127:0]           din,
    output logic [NSLOTS*128-1:0]  history
);
    always_ff @(posedge clk or posedge reset)
        if (reset) history <= {NSLOTS{SPACES}};
        else if (load) history <= {history[(NSLOTS-1)*128-1:0], din};
endmodule

// File: rtl/tcp_packet_rx.sv
// tcp_packet_rx: deframes link bytes into SEQ/ACK/flags/payload, checks sum, keeps history
module tcp_packet_rx
    import tcp_packet_rx_pkg::*;
#(
    parameter int TIMEOUT = 65000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   packet_ready,
    output logic [31:0]            seq_out,
    output logic [31:0]            ack_out,
    output logic [8:0]             flags_out,
    output logic [127:0]           payload_out,
    output logic [NSLOTS*128-1:0]  history,
    output logic                   frame_err,
    output logic [7:0]             err_count,
    output logic                   busy
);
    state_t state, next;
    logic [3:0] cnt, lenm1;
    logic [15:0] idle_cnt;
    logic [7:0] sum, csum_total;
    logic [31:0] w_seq, w_ack;
    logic [8:0] w_flags;
    logic [127:0] w_pay;
    logic has_pay, timeout, accept, drop;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_IDLE;
        else state <= next;
    always_comb begin
        next = state;
        if (timeout) next = S_IDLE;
        else if (rx_valid)
            case (state)
                S_IDLE:  next = rx_data == SOF ? S_SEQ : S_IDLE;
                S_SEQ:   next = cnt == 4'd3 ? S_ACK : S_SEQ;
                S_ACK:   next = cnt == 4'd3 ? S_FLAGS : S_ACK;
                S_FLAGS: next = cnt == 4'd1 ? S_LEN : S_FLAGS;
                S_LEN:   next = rx_data > MAXLEN ? S_IDLE : rx_data == 8'd0 ? S_CSUM : S_PAY;
                S_PAY:   next = cnt == lenm1 ? S_CSUM : S_PAY;
                default: next = S_IDLE;
            endcase
    end
    always_comb begin
        busy = state != S_IDLE;
        csum_total = sum + rx_data;
        timeout = busy && !rx_valid && idle_cnt == 16'(TIMEOUT - 1);
        accept = rx_valid && state == S_CSUM && csum_total == 8'h00;
        drop = timeout || (rx_valid && ((state == S_LEN && rx_data > MAXLEN) ||
                                        (state == S_CSUM && csum_total != 8'h00)));
    end
    // working registers shadow the frame; visible fields move only on accept
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt <= '0;
            lenm1 <= '0;
            idle_cnt <= '0;
            sum <= '0;
            w_seq <= '0;
            w_ack <= '0;
            w_flags <= '0;
            w_pay <= SPACES;
            has_pay <= 1'b0;
            packet_ready <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
            seq_out <= '0;
            ack_out <= '0;
            flags_out <= '0;
            payload_out <= SPACES;
        end else begin
            packet_ready <= accept;
            frame_err <= drop;
            if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
            cnt <= next != state ? 4'd0 : rx_valid ? cnt + 4'd1 : cnt;
            idle_cnt <= (!busy || rx_valid) ? 16'd0 : idle_cnt + 16'd1;
            if (rx_valid) begin
                sum <= state == S_IDLE ? 8'd0 : csum_total;
                case (state)
                    S_SEQ:   w_seq <= {w_seq[23:0], rx_data};
                    S_ACK:   w_ack <= {w_ack[23:0], rx_data};
                    S_FLAGS: w_flags <= {w_flags[0], rx_data};
                    S_LEN: begin
                        lenm1 <= rx_data[3:0] - 4'd1;
                        has_pay <= rx_data != 8'd0;
                        w_pay <= SPACES;
                    end
                    S_PAY:   w_pay[8*(15-cnt) +: 8] <= rx_data;
                    default: ;
                endcase
            end
            if (accept) begin
                seq_out <= w_seq;
                ack_out <= w_ack;
                flags_out <= w_flags;
                if (has_pay) payload_out <= w_pay;
            end
        end
    rx_history_shift u_hist (
        .clk(clk),
        .reset(reset),
        .load(accept && has_pay),
        .din(w_pay),
        .history(history)
    );
endmodule
